lector_cuenta: RTL and testbench
================================

// Module: lector_cuenta
// PURPOSE
//  Downstream consumer of the change counter's 5-bit `cuenta` output. Tracks
//  counter wrap-around (31->0) and widens the count into an ACC_W-bit running
//  total of data changes. Returns a snapshot of that total over a req/valid/ack
//  readout handshake, with a sticky overflow flag and a synchronous clear.
// PARAMETERS
//  CNT_W  5   width of upstream count input; wraps modulo 2^CNT_W
//  ACC_W  16  width of running total and snapshot output
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  reset      in   1      asynchronous, active-low; state cleared while low
//  cuenta_in  in   CNT_W  upstream change count; may wrap
//  clear      in   1      sync clear of total and overflow flag
//  req        in   1      snapshot request; sampled only in IDLE
//  ack        in   1      consumer accepted snapshot; sampled only in HOLD
//  total_out  out  ACC_W  snapshot of running total; stable while valid=1
//  ovf_out    out  1      snapshot of sticky overflow flag
//  valid      out  1      snapshot available
// BEHAVIOUR
//  Reset (reset=0, async): prev=0, acc=0, ovf=0, state=IDLE,
//   total_out=0, ovf_out=0, valid=0. Upstream also resets its count to 0.
//  Every cycle, all states:
//   delta = (cuenta_in - prev) mod 2^CNT_W. Unsigned, CNT_W bits.
//   {carry, acc_next} = acc + delta, zero-extended to ACC_W+1 bits.
//   prev <= cuenta_in.
//  Accumulator update:
//   clear=1: acc <= 0, ovf <= 0. delta of that cycle is discarded.
//   Otherwise: acc <= acc_next (wraps modulo 2^ACC_W); ovf <= ovf | carry.
//  FSM, 2 states:
//   IDLE: valid=0. On req=1: total_out <= acc_next, ovf_out <= ovf|carry,
//    state <= HOLD. The snapshot is the pre-clear value even when clear=1
//    in the same cycle.
//   HOLD: valid=1. total_out and ovf_out are frozen. req is ignored.
//    Accumulation continues. On ack=1: state <= IDLE, so valid=0 on the
//    next cycle.
//  Latency: req at edge t gives valid=1 after edge t. ack at edge u gives
//   valid=0 after edge u. A new req is accepted at edge u+1 at the earliest.
//  ack in IDLE and req in HOLD have no effect.
//  reset asserted mid-HOLD: valid drops immediately (async); the snapshot
//   is lost.
//  Upstream rises by at most 1 per cycle, so delta is 0 or 1 in normal use.
//   Larger deltas, e.g. after a sample gap, are still accumulated correctly
//   modulo 2^CNT_W.
// TESTING
//  1. Reset; cuenta_in 0->1->2->3 on successive cycles; req at the cycle
//     after reaching 3 -> valid=1 next cycle, total_out=3, ovf_out=0.
//  2. cuenta_in steps 29,30,31,0,1 starting from total 29 -> req gives
//     total_out=33. Wrap is handled with no loss.
//  3. ACC_W=4: advance the total to 15, then one more change -> req gives
//     total_out=0, ovf_out=1. clear, then req -> total_out=0, ovf_out=0.
//  4. In HOLD, 5 upstream changes occur -> total_out is unchanged. ack, then
//     req -> total_out rises by 5. A req pulsed during HOLD is ignored.
//  5. req and clear in the same cycle with total 7 -> total_out=7. A later
//     req with no changes -> total_out=0.
//  6. Assert reset asynchronously between clock edges while valid=1 -> valid,
//     total_out and ovf_out go to 0 immediately. Deassert; next req -> 0.

Source files
------------

// File: rtl/lector_cuenta.sv
// Widens the upstream wrapping change count into a running total with a sticky
// overflow flag, and hands out snapshots of it over a req/valid/ack handshake.
module lector_cuenta #(
  parameter int CNT_W = 5,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cuenta_in,
  input  logic             clear,
  input  logic             req,
  input  logic             ack,
  output logic [ACC_W-1:0] total_out,
  output logic             ovf_out,
  output logic             valid
);

  // state   | meaning
  // ST_IDLE | no snapshot held; req captures one
  // ST_HOLD | snapshot frozen on total_out/ovf_out; ack releases it
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_prev;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] r_total;
  logic             r_ovf_snap;
  logic             r_valid;

  logic [CNT_W-1:0] w_delta;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;

  // Modular subtraction absorbs the upstream 31->0 wrap.
  assign w_delta = cuenta_in - r_prev;
  assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, w_delta};
  assign w_carry = w_sum[ACC_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_prev <= cuenta_in;
      if (clear) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_carry;
      end
    end
  end

  // The snapshot takes the pre-clear sum, so a same-cycle clear never hides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_total    <= '0;
      r_ovf_snap <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_total    <= w_sum[ACC_W-1:0];
            r_ovf_snap <= r_ovf | w_carry;
            r_valid    <= 1'b1;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign total_out = r_total;
  assign ovf_out   = r_ovf_snap;
  assign valid     = r_valid;

endmodule

// File: tb/tb_lector_cuenta.sv
// Randomized and directed bench for lector_cuenta against a change-count model
// that keeps the unbounded number of changes since the last clear.
module tb_lector_cuenta;

  logic        clk;
  logic        reset;
  logic [4:0]  cuenta_in;
  logic        clear;
  logic        req;
  logic        ack;
  logic [15:0] total_out;
  logic        ovf_out;
  logic        valid;

  int n_vec;
  int n_err;

  // Reference: changes since clear as a plain integer; total and overflow derive from it.
  longint m_count;
  int     m_prev;
  bit     m_hold;
  longint m_total;
  bit     m_ovf;
  int     cur;

  lector_cuenta #(.CNT_W(5), .ACC_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cuenta_in (cuenta_in),
    .clear     (clear),
    .req       (req),
    .ack       (ack),
    .total_out (total_out),
    .ovf_out   (ovf_out),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_prev  = 0;
    m_hold  = 0;
    m_total = 0;
    m_ovf   = 0;
    cur     = 0;
  endtask

  task automatic step(input int cin, input bit clr, input bit rq, input bit ak);
    longint nxt;
    int d;
    @(negedge clk);
    cuenta_in = 5'(cin);
    clear     = clr;
    req       = rq;
    ack       = ak;
    d   = ((cin % 32) - m_prev + 32) % 32;
    nxt = m_count + d;
    if (!m_hold && rq) begin
      m_total = nxt % 65536;
      m_ovf   = (nxt >= 65536);
      m_hold  = 1;
    end else if (m_hold && ak) begin
      m_hold = 0;
    end
    m_count = clr ? 0 : nxt;
    m_prev  = cin % 32;
    cur     = cin % 32;
    @(posedge clk);
    #1;
    chk("valid", longint'(valid), longint'(m_hold));
    chk("total", longint'(total_out), m_total);
    chk("ovf", longint'(ovf_out), longint'(m_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    cuenta_in = '0;
    clear     = 1'b0;
    req       = 1'b0;
    ack       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid", longint'(valid), 0);
    chk("rst_total", longint'(total_out), 0);
    chk("rst_ovf", longint'(ovf_out), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic release_hold();
    if (m_hold) step(cur, 0, 0, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    cuenta_in = '0;
    clear = 1'b0;
    req = 1'b0;
    ack = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Count to 3, then request.
    for (int i = 1; i <= 3; i++) step(i, 0, 0, 0);
    step(3, 0, 1, 0);
    chk("t1_total", longint'(total_out), 3);
    chk("t1_valid", longint'(valid), 1);
    step(3, 0, 0, 1);
    chk("t1_ack", longint'(valid), 0);

    // Wrap of the upstream count from total 29.
    do_reset();
    for (int i = 1; i <= 29; i++) step(i, 0, 0, 0);
    step(30, 0, 0, 0);
    step(31, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("t2_wrap", longint'(total_out), 33);

    // Changes while holding are accumulated but not shown; req in HOLD ignored.
    for (int i = 2; i <= 6; i++) step(i, 0, (i == 4), 0);
    chk("t4_frozen", longint'(total_out), 33);
    step(6, 0, 0, 1);
    step(6, 0, 1, 0);
    chk("t4_plus5", longint'(total_out), 38);
    step(6, 0, 0, 1);

    // req with clear in the same cycle returns the pre-clear total.
    do_reset();
    for (int i = 1; i <= 7; i++) step(i, 0, 0, 0);
    step(7, 1, 1, 0);
    chk("t5_preclr", longint'(total_out), 7);
    step(7, 0, 0, 1);
    step(7, 0, 1, 0);
    chk("t5_after", longint'(total_out), 0);

    // Async reset between edges while valid is high.
    #3;
    reset = 1'b0;
    #1;
    chk("t6_valid", longint'(valid), 0);
    chk("t6_total", longint'(total_out), 0);
    chk("t6_ovf", longint'(ovf_out), 0);
    cuenta_in = '0;
    req = 1'b0;
    ack = 1'b0;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1, 0);
    chk("t6_req", longint'(total_out), 0);
    step(0, 0, 0, 1);

    // Large deltas drive the 16-bit total past its limit.
    for (int i = 0; i < 3500; i++)
      step((cur + $urandom_range(20, 31)) % 32, 0,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    release_hold();
    step(cur, 0, 1, 0);
    chk("ovf_set", longint'(ovf_out), 1);
    step(cur, 0, 0, 1);
    step(cur, 1, 0, 0);
    step(cur, 0, 1, 0);
    chk("clr_total", longint'(total_out), 0);
    chk("clr_ovf", longint'(ovf_out), 0);
    step(cur, 0, 0, 1);

    // Normal traffic: mostly +0/+1, occasional sample gaps and clears.
    for (int i = 0; i < 2000; i++) begin
      int c;
      if ($urandom_range(0, 31) == 0) c = $urandom_range(0, 31);
      else c = (cur + $urandom_range(0, 1)) % 32;
      step(c, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
